// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: RV32I byte/half/word loads and
// stores behind a valid/ready request handshake, answered after LATENCY cycles.

// One byte lane of the data array; no reset, contents survive pipeline reset.
module dmem_lane #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**AW];

  // byte write on the accept edge; read is combinational so it lands in the same edge
  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module dmem_responder #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);
  localparam int NUM_LANES = 4;
  localparam int WAW       = DM_ADDRESS - 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  state_t                      state;
  logic [3:0]                  cnt;
  rsp_t                        pend, rsp_nxt;
  logic                        accept, bad;
  logic [NUM_LANES-1:0][7:0]   rd_lanes, wr_lanes;
  logic [NUM_LANES-1:0]        be;
  logic [7:0]                  byte_sel;
  logic [15:0]                 half_sel;
  logic [DATA_W-1:0]           ld_data;

  assign accept = req_valid & req_ready;

  // decode access legality, lane selection/extension and store byte enables
  always_comb begin
    bad      = 1'b0;
    ld_data  = '0;
    wr_lanes = '0;
    be       = '0;
    case (req_addr[1:0])
      2'd0:    byte_sel = rd_lanes[0];
      2'd1:    byte_sel = rd_lanes[1];
      2'd2:    byte_sel = rd_lanes[2];
      default: byte_sel = rd_lanes[3];
    endcase
    half_sel = req_addr[1] ? {rd_lanes[3], rd_lanes[2]} : {rd_lanes[1], rd_lanes[0]};
    case (req_funct3)
      3'b000: begin
        ld_data  = {{24{byte_sel[7]}}, byte_sel};
        wr_lanes = {NUM_LANES{req_wdata[7:0]}};
        be       = 4'b0001 << req_addr[1:0];
      end
      3'b001: begin
        bad      = req_addr[0];
        ld_data  = {{16{half_sel[15]}}, half_sel};
        wr_lanes = {2{req_wdata[15:0]}};
        be       = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        bad      = (req_addr[1:0] != 2'b00);
        ld_data  = rd_lanes;
        wr_lanes = req_wdata;
        be       = 4'b1111;
      end
      3'b100: begin
        bad     = req_we;
        ld_data = {24'h0, byte_sel};
      end
      3'b101: begin
        bad     = req_we | req_addr[0];
        ld_data = {16'h0, half_sel};
      end
      default: bad = 1'b1;
    endcase
    if (!(accept && req_we && !bad && !reset)) be = '0;
    rsp_nxt.err   = bad;
    rsp_nxt.rdata = (bad || req_we) ? '0 : ld_data;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dmem_lane #(.AW(WAW)) u_lane (
      .clk   (clk),
      .we    (be[l]),
      .idx   (req_addr[DM_ADDRESS-1:2]),
      .wdata (wr_lanes[l]),
      .rdata (rd_lanes[l])
    );
  end

  // IDLE/RESP accept, WAIT counts down, RESP pulses the registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      pend      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rsp_nxt.rdata;
              rsp_err   <= rsp_nxt.err;
              req_ready <= 1'b1;
            end else begin
              state     <= WAIT;
              cnt       <= 4'(LATENCY - 1);
              pend      <= rsp_nxt;
              req_ready <= 1'b0;
            end
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= pend.rdata;
            rsp_err   <= pend.err;
            req_ready <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses are queued at accept
// and compared (value and latency) when rsp_valid pulses.
module tb_dmem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   last_acc = 0;

  dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // present a request from a negedge and hold it until the DUT is ready
  task automatic send(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, input logic exp_err, input logic [31:0] exp_rd,
                      input bit push, input bit b2b);
    int   guard = 0;
    exp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 32'(guard), 0);
    if (b2b) chk("b2b_gap", 32'(cyc - last_acc), LAT);
    last_acc = cyc;
    e.err = exp_err; e.rdata = exp_rd; e.cyc = cyc;
    if (push) q.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // compare each response with the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rsp_valid) begin
      if (q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        e = q.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("latency", 32'(cyc - e.cyc), LAT);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err",   32'(rsp_err), 0);
    reset = 1'b0;

    // 1: SW then LW, ready drops for one cycle after accept
    send(1, 9'h010, 32'hDEADBEEF, 3'b010, 0, 0, 1, 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ready_low_wait", 32'(req_ready), 0);
    @(negedge clk);
    chk("ready_back_resp", 32'(req_ready), 1);
    send(0, 9'h010, 0, 3'b010, 0, 32'hDEADBEEF, 1, 0);
    idle(3);

    // 2: byte store and byte loads
    send(1, 9'h013, 32'h000000F0, 3'b000, 0, 0, 1, 0);
    send(0, 9'h010, 0, 3'b010, 0, 32'hF0ADBEEF, 1, 1);
    send(0, 9'h013, 0, 3'b000, 0, 32'hFFFFFFF0, 1, 1);
    send(0, 9'h013, 0, 3'b100, 0, 32'h000000F0, 1, 1);
    idle(3);

    // 3: half store into the upper half of a known word
    send(1, 9'h020, 32'h11223344, 3'b010, 0, 0, 1, 0);
    send(1, 9'h022, 32'h00008001, 3'b001, 0, 0, 1, 1);
    send(0, 9'h022, 0, 3'b001, 0, 32'hFFFF8001, 1, 1);
    send(0, 9'h022, 0, 3'b101, 0, 32'h00008001, 1, 1);
    send(0, 9'h020, 0, 3'b010, 0, 32'h80013344, 1, 1);
    idle(3);

    // 4: rejected accesses leave memory untouched
    send(0, 9'h011, 0, 3'b010, 1, 0, 1, 0);
    send(1, 9'h023, 32'h0000FFFF, 3'b001, 1, 0, 1, 1);
    send(1, 9'h010, 32'h0, 3'b011, 1, 0, 1, 1);
    send(1, 9'h011, 32'h0, 3'b100, 1, 0, 1, 1);
    send(0, 9'h020, 0, 3'b010, 0, 32'h80013344, 1, 1);
    send(0, 9'h010, 0, 3'b010, 0, 32'hF0ADBEEF, 1, 1);
    idle(3);

    // 5: six back-to-back requests with valid held high
    for (int i = 0; i < 3; i++) begin
      send(1, 9'(9'h040 + 4*i), 32'hA5000000 + 32'(i), 3'b010, 0, 0, 1, i != 0);
      send(0, 9'(9'h040 + 4*i), 0, 3'b010, 0, 32'hA5000000 + 32'(i), 1, 1);
    end
    idle(4);
    chk("b2b_drained", 32'(q.size()), 0);

    // 6: reset during WAIT drops the response but keeps the store
    send(1, 9'h030, 32'h12345678, 3'b010, 0, 0, 0, 0);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("post_rst_ready", 32'(req_ready), 1);
    chk("post_rst_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("post_rst_novalid", 32'(rsp_valid), 0);
    send(0, 9'h030, 0, 3'b010, 0, 32'h12345678, 1, 0);
    idle(5);

    chk("queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
